usb_rx_bit_datapath: RTL and testbench
======================================

Name: usb_rx_bit_datapath

Overview:
- Receive bit-level datapath of the UTMI-style USB receiver. It runs at the 480 MHz bit-sample rate.
- It NRZI-decodes the sampled D+ line and removes USB stuffed bits, then shifts bits LSB-first into W-bit words with a one-cycle valid strobe.
- It sits between the sync/EOP detector, which supplies the enable, and the RX control FSM/UTMI byte interface.

Parameters:
- W, 8, output word width in bits (number of unstuffed bits per rx_valid strobe).

Ports:
- clk_480mhz input 1 bit-sample clock; one line sample per cycle.
- rst input 1 reset; rst synchronous, active-high; clock clk_480mhz.
- dp_in input 1 sampled D+ line level.
- en input 1 packet active from the sync detector; high while bits after SYNC are valid, low at EOP/idle.
- rx_data output W assembled word, LSB = first received bit.
- rx_valid output 1 single-cycle strobe; rx_data is valid while it is high.

Behaviour:
- Reset (rst=1 at a clk edge):
  - prev_line=1 (idle J); all valid flags=0; ones_cnt=0; bit_cnt=0; shift register=0.
  - rx_data=0; rx_valid=0.
  - Reset mid-packet drops any partial word, with no strobe.
- Stage 1, NRZI decode (registered):
  - dec_bit = ~(dp_in ^ prev_line), so no transition gives 1 and a transition gives 0.
  - dec_valid = en.
  - prev_line <= dp_in every cycle, regardless of en.
- Stage 2, bit unstuffer (registered), acting on dec_valid cycles:
  - dec_bit=1 and ones_cnt<6: pass the bit, ones_cnt++.
  - dec_bit=0 and ones_cnt<6: pass the bit, ones_cnt=0.
  - ones_cnt==6: the bit is a stuffed bit. Drop it (ust_valid=0) and set ones_cnt=0.
    - If the stuffed bit is 1, that is a stuff error (see Optional Feature).
  - dec_valid=0: ones_cnt=0, ust_valid=0.
- Stage 3, hold/shift (registered):
  - On ust_valid: shift = {ust_bit, shift[W-1:1]} and bit_cnt++.
  - When bit_cnt reaches W-1 with ust_valid: load the completed word into rx_data, pulse rx_valid, and set bit_cnt=0.
  - rx_data holds its value until the next completed word.
- Abort:
  - Stage-1 en low (dec_valid=0) clears bit_cnt and ones_cnt.
  - A partial word is discarded silently.
- Latency: rx_valid rises 3 cycles after the edge that samples the last bit of a word.
- Throughput: back-to-back words strobe every W cycles, plus one cycle per removed stuffed bit.
- No backpressure: the consumer must accept each strobe.

Optional Feature:
- Macro RX_STUFF_ERR_EN.
- Defined:
  - Adds output rx_stuff_err (1 bit).
  - It pulses for one cycle, aligned with the stage-3 output timing, when a stuffed-bit slot holds 1.
  - The current partial word is discarded (bit_cnt=0) and reception continues.
- Undefined:
  - No port.
  - A 1 in a stuffed slot is dropped silently like any stuffed bit; the partial word is kept.

Decomposition:
- Package usb_rx_pkg:
  - STUFF_LIMIT=6.
  - J_IDLE=1'b1.
  - Localparam for the bit-counter width, $clog2(W).
- One natural sub-module: usb_rx_unstuff (stage-2 counter/drop logic).
- NRZI and shift stages stay inline in the top.

Test Plan:
- Reset, en=1, dp_in=1,0,0,1,0,0,1,1 -> exactly one rx_valid, 3 cycles after the 8th sample, with rx_data=8'hA5.
- Two bytes 8'hFF,8'hFF: after every 6 decoded 1s, insert one transition (stuffed 0) on dp_in -> two strobes, data FF then FF, stuffed bits absent; second strobe 9 cycles after the first.
- Seven consecutive non-transitions (stuff slot=1):
  - with RX_STUFF_ERR_EN -> one rx_stuff_err pulse, no rx_valid for that partial word;
  - without it -> the bit is dropped, no error port.
- en dropped after 5 bits, then a new packet sending 8'h3C -> the first partial word yields no strobe; the second gives rx_data=8'h3C with rx_valid.
- rst asserted for 1 cycle mid-word, then 8'h01 sent -> no stale strobe; rx_data=8'h01 after its 8th bit (+3 cycles).
- Continuous 4 bytes 8'h00 (toggle every sample) -> rx_valid every 8 cycles, rx_data=8'h00 each time.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// Shared constants for the USB receive bit datapath.
// Optional build macro RX_STUFF_ERR_EN is consumed by the modules that import this package.
package usb_rx_pkg;

    localparam int unsigned STUFF_LIMIT = 6;
    localparam logic        J_IDLE      = 1'b1;
    localparam int unsigned W_DEFAULT   = 8;
    localparam int unsigned ONES_CNT_W  = $clog2(STUFF_LIMIT + 1);

    // Bit-counter width for a W-bit word; never narrower than one bit.
    function automatic int unsigned bit_cnt_w(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/usb_rx_unstuff.sv
// Stage 2: counts consecutive decoded ones and drops the bit following six of them.
// With RX_STUFF_ERR_EN defined, a 1 in a stuffed slot is flagged on ust_err_o.
module usb_rx_unstuff
    import usb_rx_pkg::*;
(
    input  logic clk_480mhz,
    input  logic rst,
    input  logic dec_bit_i,
    input  logic dec_valid_i,
    output logic ust_bit_o,
    output logic ust_valid_o,
`ifdef RX_STUFF_ERR_EN
    output logic ust_err_o,
`endif
    output logic ust_abort_o
);

    logic [ONES_CNT_W-1:0] ones_q, ones_d;
    logic                  bit_q, bit_d;
    logic                  valid_q, valid_d;
    logic                  abort_q, abort_d;
`ifdef RX_STUFF_ERR_EN
    logic                  err_q, err_d;
`endif

    always_comb begin
        ones_d  = ones_q;
        bit_d   = dec_bit_i;
        valid_d = 1'b0;
        abort_d = ~dec_valid_i;
`ifdef RX_STUFF_ERR_EN
        err_d   = 1'b0;
`endif
        if (!dec_valid_i) begin
            ones_d = '0;
        end else if (ones_q == ONES_CNT_W'(STUFF_LIMIT)) begin
            // Stuffed slot: never forwarded.
            ones_d = '0;
`ifdef RX_STUFF_ERR_EN
            err_d  = dec_bit_i;
`endif
        end else begin
            valid_d = 1'b1;
            ones_d  = dec_bit_i ? ones_q + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk_480mhz) begin
        if (rst) begin
            ones_q  <= '0;
            bit_q   <= 1'b0;
            valid_q <= 1'b0;
            abort_q <= 1'b0;
`ifdef RX_STUFF_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            ones_q  <= ones_d;
            bit_q   <= bit_d;
            valid_q <= valid_d;
            abort_q <= abort_d;
`ifdef RX_STUFF_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    assign ust_bit_o   = bit_q;
    assign ust_valid_o = valid_q;
    assign ust_abort_o = abort_q;
`ifdef RX_STUFF_ERR_EN
    assign ust_err_o   = err_q;
`endif

endmodule

// File: rtl/usb_rx_bit_datapath.sv
// USB RX bit datapath: NRZI decode, bit unstuffing and LSB-first word assembly.
// Define RX_STUFF_ERR_EN to add the rx_stuff_err_o output and discard words on stuff errors.
module usb_rx_bit_datapath
    import usb_rx_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic         clk_480mhz,
    input  logic         rst,
    input  logic         dp_in_i,
    input  logic         en_i,
    output logic [W-1:0] rx_data_o,
`ifdef RX_STUFF_ERR_EN
    output logic         rx_stuff_err_o,
`endif
    output logic         rx_valid_o
);

    localparam int unsigned CntW = bit_cnt_w(W);

    // Stage 1: NRZI decode; the line history tracks dp_in even while idle.
    logic prev_line_q, dec_bit_q, dec_valid_q;

    always_ff @(posedge clk_480mhz) begin
        if (rst) begin
            prev_line_q <= J_IDLE;
            dec_bit_q   <= 1'b0;
            dec_valid_q <= 1'b0;
        end else begin
            prev_line_q <= dp_in_i;
            dec_bit_q   <= ~(dp_in_i ^ prev_line_q);
            dec_valid_q <= en_i;
        end
    end

    // Stage 2: unstuffer.
    logic ust_bit, ust_valid, ust_abort;
`ifdef RX_STUFF_ERR_EN
    logic ust_err;
`endif

    usb_rx_unstuff u_unstuff (
        .clk_480mhz  (clk_480mhz),
        .rst         (rst),
        .dec_bit_i   (dec_bit_q),
        .dec_valid_i (dec_valid_q),
        .ust_bit_o   (ust_bit),
        .ust_valid_o (ust_valid),
`ifdef RX_STUFF_ERR_EN
        .ust_err_o   (ust_err),
`endif
        .ust_abort_o (ust_abort)
    );

    // Stage 3: shift and word hold.
    logic [W-1:0]    shift_q, shift_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    data_q, data_d;
    logic            valid_q, valid_d;
`ifdef RX_STUFF_ERR_EN
    logic            err_q, err_d;
`endif

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = 1'b0;
`ifdef RX_STUFF_ERR_EN
        err_d   = 1'b0;
`endif
        if (ust_abort) begin
            cnt_d = '0;
`ifdef RX_STUFF_ERR_EN
        end else if (ust_err) begin
            cnt_d = '0;
            err_d = 1'b1;
`endif
        end else if (ust_valid) begin
            shift_d = {ust_bit, shift_q[W-1:1]};
            if (cnt_q == CntW'(W - 1)) begin
                data_d  = shift_d;
                valid_d = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_480mhz) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
`ifdef RX_STUFF_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
`ifdef RX_STUFF_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    assign rx_data_o  = data_q;
    assign rx_valid_o = valid_q;
`ifdef RX_STUFF_ERR_EN
    assign rx_stuff_err_o = err_q;
`endif

endmodule

// File: tb/tb_usb_rx_bit_datapath.sv
// Scoreboard bench for usb_rx_bit_datapath: driver pushes expected words, monitor checks strobes.
`timescale 1ns/100ps
module tb_usb_rx_bit_datapath;

    logic       clk_480mhz = 1'b0;
    logic       rst = 1'b1;
    logic       dp_in = 1'b1;
    logic       en = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
`ifdef RX_STUFF_ERR_EN
    logic       rx_stuff_err;
`endif

    usb_rx_bit_datapath #(.W(8)) dut (
        .clk_480mhz     (clk_480mhz),
        .rst            (rst),
        .dp_in_i        (dp_in),
        .en_i           (en),
        .rx_data_o      (rx_data),
`ifdef RX_STUFF_ERR_EN
        .rx_stuff_err_o (rx_stuff_err),
`endif
        .rx_valid_o     (rx_valid)
    );

    always #1 clk_480mhz = ~clk_480mhz;

    int cyc = 0;
    always @(posedge clk_480mhz) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t exp_q[$];
    int   strobe_cyc[$];
`ifdef RX_STUFF_ERR_EN
    int   err_q[$];
`endif
    int   total = 0;
    int   bad = 0;
    logic line = 1'b1;
    int   tx_ones = 0;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Monitor: every strobe must match the oldest expected word, on its due cycle.
    always @(negedge clk_480mhz) begin
        if (rx_valid) begin
            strobe_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: got rx_data=%0h want no strobe", rx_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rx_data", int'(rx_data), int'(e.data));
                chk("strobe_cycle", cyc, e.due);
            end
        end
`ifdef RX_STUFF_ERR_EN
        if (rx_stuff_err) begin
            if (err_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_stuff_err: got pulse at %0d want none", cyc);
            end else begin
                chk("stuff_err_cycle", cyc, err_q.pop_front());
            end
        end
`endif
    end

    task automatic drive(input logic lvl, input logic e);
        @(negedge clk_480mhz);
        dp_in = lvl;
        en    = e;
        line  = lvl;
    endtask

    // NRZI transmit: 1 keeps the line, 0 toggles it.
    task automatic send_dec(input logic b);
        drive(b ? line : ~line, 1'b1);
        tx_ones = b ? tx_ones + 1 : 0;
    endtask

    // Called right after the last bit of a word was driven.
    task automatic expect_word(input logic [7:0] d);
        exp_t e;
        e.data = d;
        e.due  = cyc + 3;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] d);
        for (int i = 0; i < 8; i++) begin
            send_dec(d[i]);
            if (i == 7) expect_word(d);
            if (tx_ones == 6) send_dec(1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(line, 1'b0);
        tx_ones = 0;
    endtask

    initial begin
        logic [7:0] a5_line;
        logic [7:0] d5a;
        int         n;
        a5_line = 8'b1100_1001; // dp_in 1,0,0,1,0,0,1,1 read LSB first
        d5a     = 8'h5A;

        repeat (3) @(negedge clk_480mhz);
        chk("reset_rx_data", int'(rx_data), 0);
        chk("reset_rx_valid", int'(rx_valid), 0);
        @(negedge clk_480mhz);
        rst = 1'b0;
        idle(2);

        // Raw line levels decoding to 8'hA5.
        for (int i = 0; i < 8; i++) drive(a5_line[i], 1'b1);
        expect_word(8'hA5);
        idle(6);

        // Two 8'hFF bytes with stuffed zeros.
        send_byte(8'hFF);
        send_byte(8'hFF);
        idle(6);
        n = strobe_cyc.size();
        chk("ff_strobe_count", n, 3);
        if (n >= 2) chk("ff_spacing", strobe_cyc[n-1] - strobe_cyc[n-2], 9);

        // Seven ones: the seventh lands in the stuffed slot.
        for (int i = 0; i < 7; i++) begin
            send_dec(1'b1);
`ifdef RX_STUFF_ERR_EN
            if (i == 6) err_q.push_back(cyc + 3);
`endif
        end
        tx_ones = 0; // the receiver restarts its run after the stuffed slot
        for (int i = 0; i < 8; i++) begin
            send_dec(d5a[i]);
`ifdef RX_STUFF_ERR_EN
            if (i == 7) expect_word(8'h5A);
`else
            // Six kept ones plus the first two bits of 8'h5A.
            if (i == 1) expect_word(8'hBF);
`endif
        end
        idle(6);

        // Abort after five bits, then a fresh packet.
        send_dec(1'b1);
        send_dec(1'b0);
        send_dec(1'b1);
        send_dec(1'b1);
        send_dec(1'b0);
        idle(3);
        send_byte(8'h3C);
        idle(6);

        // Reset mid-word.
        for (int i = 0; i < 4; i++) send_dec(1'b0);
        @(negedge clk_480mhz);
        rst   = 1'b1;
        en    = 1'b0;
        dp_in = 1'b1;
        line  = 1'b1;
        @(negedge clk_480mhz);
        rst = 1'b0;
        chk("post_reset_rx_data", int'(rx_data), 0);
        chk("post_reset_rx_valid", int'(rx_valid), 0);
        tx_ones = 0;
        send_byte(8'h01);
        idle(6);

        // Four back-to-back zero bytes.
        for (int k = 0; k < 4; k++) send_byte(8'h00);
        idle(8);
        n = strobe_cyc.size();
        if (n >= 4) begin
            for (int k = 1; k < 4; k++) chk("zero_spacing", strobe_cyc[n-k] - strobe_cyc[n-k-1], 8);
        end else begin
            chk("zero_strobe_count", n, 4);
        end

        chk("pending_words", exp_q.size(), 0);
`ifdef RX_STUFF_ERR_EN
        chk("pending_errs", err_q.size(), 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
